// File: rtl/response_tree_pipe_bridge_pkg.sv
// Shared elaboration helpers for the response fan-in tree: depth, latency and
// register placement.
package response_tree_pipe_bridge_pkg;

   function automatic int unsigned tree_levels(input int unsigned n);
      return (n <= 1) ? 0 : $clog2(n);
   endfunction

   function automatic int unsigned src_width(input int unsigned n);
      return (tree_levels(n) == 0) ? 1 : tree_levels(n);
   endfunction

   function automatic int unsigned pipe_latency(input int unsigned levels,
                                                input int unsigned stride);
      return (stride == 0) ? 0 : levels / stride;
   endfunction

   // Level numbering starts at 1 for the node row next to the leaves.
   function automatic bit is_pipe_level(input int unsigned l, input int unsigned stride);
      if (stride == 0) return 1'b0;
      return (l % stride) == 0;
   endfunction

endpackage

// File: rtl/response_tree_pipe_bridge_if.sv
// Per-slave response channels in, merged master response and collision status out.
interface response_tree_pipe_bridge_if
   import response_tree_pipe_bridge_pkg::*;
#(
   parameter int unsigned N_SLAVE    = 16,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned AUX_WIDTH  = 8,
   parameter int unsigned CNT_WIDTH  = 8,
   parameter int unsigned SRC_WIDTH  = src_width(N_SLAVE)
);
   logic [N_SLAVE-1:0]            data_r_valid_i;
   logic [N_SLAVE*DATA_WIDTH-1:0] data_r_rdata_i;
   logic [N_SLAVE-1:0]            data_r_opc_i;
   logic [N_SLAVE*AUX_WIDTH-1:0]  data_r_aux_i;
   logic                          clr_cnt_i;
   logic                          data_r_valid_o;
   logic [DATA_WIDTH-1:0]         data_r_rdata_o;
   logic                          data_r_opc_o;
   logic [AUX_WIDTH-1:0]          data_r_aux_o;
   logic [SRC_WIDTH-1:0]          data_r_src_o;
   logic                          collision_o;
   logic [CNT_WIDTH-1:0]          collision_cnt_o;

   modport master (
      output data_r_valid_i, data_r_rdata_i, data_r_opc_i, data_r_aux_i, clr_cnt_i,
      input  data_r_valid_o, data_r_rdata_o, data_r_opc_o, data_r_aux_o, data_r_src_o,
             collision_o, collision_cnt_o
   );

   modport slave (
      input  data_r_valid_i, data_r_rdata_i, data_r_opc_i, data_r_aux_i, clr_cnt_i,
      output data_r_valid_o, data_r_rdata_o, data_r_opc_o, data_r_aux_o, data_r_src_o,
             collision_o, collision_cnt_o
   );
endinterface

// File: rtl/response_tree_pipe_bridge_fanin_node.sv
// 2:1 response merge, lower input wins; optionally registered output stage.
module response_tree_pipe_bridge_fanin_node #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned AUX_WIDTH  = 8,
   parameter int unsigned SRC_WIDTH  = 4,
   parameter int unsigned LEVEL      = 1,
   parameter bit          REG_OUT    = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in0_valid_i,
   input  logic [DATA_WIDTH-1:0] in0_rdata_i,
   input  logic                  in0_opc_i,
   input  logic [AUX_WIDTH-1:0]  in0_aux_i,
   input  logic [SRC_WIDTH-1:0]  in0_src_i,
   input  logic                  in0_coll_i,
   input  logic                  in1_valid_i,
   input  logic [DATA_WIDTH-1:0] in1_rdata_i,
   input  logic                  in1_opc_i,
   input  logic [AUX_WIDTH-1:0]  in1_aux_i,
   input  logic [SRC_WIDTH-1:0]  in1_src_i,
   input  logic                  in1_coll_i,
   output logic                  out_valid_o,
   output logic [DATA_WIDTH-1:0] out_rdata_o,
   output logic                  out_opc_o,
   output logic [AUX_WIDTH-1:0]  out_aux_o,
   output logic [SRC_WIDTH-1:0]  out_src_o,
   output logic                  out_coll_o
);
   logic                  sel;
   logic                  valid_d, valid_q, opc_d, opc_q, coll_d, coll_q;
   logic [DATA_WIDTH-1:0] rdata_d, rdata_q;
   logic [AUX_WIDTH-1:0]  aux_d, aux_q;
   logic [SRC_WIDTH-1:0]  src_d, src_q;

   always_comb begin
      sel     = ~in0_valid_i;
      valid_d = in0_valid_i | in1_valid_i;
      coll_d  = (in0_valid_i & in1_valid_i) | in0_coll_i | in1_coll_i;
      rdata_d = sel ? in1_rdata_i : in0_rdata_i;
      opc_d   = sel ? in1_opc_i : in0_opc_i;
      aux_d   = sel ? in1_aux_i : in0_aux_i;
      // Children only populate the low LEVEL-1 bits, so this level's select lands above them.
      src_d   = (sel ? in1_src_i : in0_src_i) | (SRC_WIDTH'(sel) << (LEVEL - 1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         coll_q  <= 1'b0;
         rdata_q <= '0;
         opc_q   <= 1'b0;
         aux_q   <= '0;
         src_q   <= '0;
      end else begin
         valid_q <= valid_d;
         coll_q  <= coll_d;
         if (valid_d) begin
            rdata_q <= rdata_d;
            opc_q   <= opc_d;
            aux_q   <= aux_d;
            src_q   <= src_d;
         end
      end
   end

   assign out_valid_o = REG_OUT ? valid_q : valid_d;
   assign out_coll_o  = REG_OUT ? coll_q  : coll_d;
   assign out_rdata_o = REG_OUT ? rdata_q : rdata_d;
   assign out_opc_o   = REG_OUT ? opc_q   : opc_d;
   assign out_aux_o   = REG_OUT ? aux_q   : aux_d;
   assign out_src_o   = REG_OUT ? src_q   : src_d;
endmodule

// File: rtl/response_tree_pipe_bridge.sv
// N:1 response fan-in tree with configurable pipelining, winner index and a
// saturating collision-beat counter.
module response_tree_pipe_bridge
   import response_tree_pipe_bridge_pkg::*;
#(
   parameter int unsigned N_SLAVE     = 16,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned AUX_WIDTH   = 8,
   parameter int unsigned PIPE_STRIDE = 1,
   parameter int unsigned CNT_WIDTH   = 8
) (
   input logic                         clk,
   input logic                         rst,
   response_tree_pipe_bridge_if.slave  bus
);
   localparam int unsigned LEVELS    = tree_levels(N_SLAVE);
   localparam int unsigned NPAD      = 1 << LEVELS;
   localparam int unsigned SRC_WIDTH = src_width(N_SLAVE);

   typedef struct packed {
      logic                  valid;
      logic [DATA_WIDTH-1:0] rdata;
      logic                  opc;
      logic [AUX_WIDTH-1:0]  aux;
      logic [SRC_WIDTH-1:0]  src;
      logic                  coll;
   } resp_beat_t;

   // Heap layout: node k has children 2k and 2k+1; leaves occupy NPAD..2*NPAD-1.
   resp_beat_t tree [1:2*NPAD-1];

   for (genvar i = 0; i < NPAD; i++) begin : g_leaf
      if (i < N_SLAVE) begin : g_real
         assign tree[NPAD+i] = '{valid: bus.data_r_valid_i[i],
                                 rdata: bus.data_r_rdata_i[i*DATA_WIDTH +: DATA_WIDTH],
                                 opc:   bus.data_r_opc_i[i],
                                 aux:   bus.data_r_aux_i[i*AUX_WIDTH +: AUX_WIDTH],
                                 src:   '0,
                                 coll:  1'b0};
      end else begin : g_pad
         assign tree[NPAD+i] = '0;
      end
   end

   for (genvar k = 1; k < NPAD; k++) begin : g_node
      localparam int unsigned NodeLevel = LEVELS + 1 - $clog2(k + 1);
      logic                  valid, opc, coll;
      logic [DATA_WIDTH-1:0] rdata;
      logic [AUX_WIDTH-1:0]  aux;
      logic [SRC_WIDTH-1:0]  src;

      response_tree_pipe_bridge_fanin_node #(
         .DATA_WIDTH (DATA_WIDTH),
         .AUX_WIDTH  (AUX_WIDTH),
         .SRC_WIDTH  (SRC_WIDTH),
         .LEVEL      (NodeLevel),
         .REG_OUT    (is_pipe_level(NodeLevel, PIPE_STRIDE))
      ) u_node (
         .clk         (clk),
         .rst         (rst),
         .in0_valid_i (tree[2*k].valid),
         .in0_rdata_i (tree[2*k].rdata),
         .in0_opc_i   (tree[2*k].opc),
         .in0_aux_i   (tree[2*k].aux),
         .in0_src_i   (tree[2*k].src),
         .in0_coll_i  (tree[2*k].coll),
         .in1_valid_i (tree[2*k+1].valid),
         .in1_rdata_i (tree[2*k+1].rdata),
         .in1_opc_i   (tree[2*k+1].opc),
         .in1_aux_i   (tree[2*k+1].aux),
         .in1_src_i   (tree[2*k+1].src),
         .in1_coll_i  (tree[2*k+1].coll),
         .out_valid_o (valid),
         .out_rdata_o (rdata),
         .out_opc_o   (opc),
         .out_aux_o   (aux),
         .out_src_o   (src),
         .out_coll_o  (coll)
      );

      assign tree[k] = '{valid: valid, rdata: rdata, opc: opc, aux: aux, src: src, coll: coll};
   end

   assign bus.data_r_valid_o = tree[1].valid;
   assign bus.data_r_rdata_o = tree[1].rdata;
   assign bus.data_r_opc_o   = tree[1].opc;
   assign bus.data_r_aux_o   = tree[1].aux;
   assign bus.data_r_src_o   = tree[1].src;
   assign bus.collision_o    = tree[1].coll;

   logic [CNT_WIDTH-1:0] cnt_d, cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (bus.clr_cnt_i) begin
         cnt_d = '0;
      end else if (tree[1].valid && tree[1].coll && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign bus.collision_cnt_o = cnt_q;
endmodule
